adler32_checker: RTL and testbench

- Receive-side companion of the Adler-32 generator: consumes a framed byte stream (length, payload, 4-byte Adler-32 trailer), recomputes Adler-32 over the payload and reports match/mismatch.
- Sits at the receiving end of the byte link; its done/checksum_ok outputs go to the frame-accept logic.

---
 rtl/adler32_checker.sv | 131 +++++++++++++
 tb/tb_adler32_checker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/adler32_checker.sv
// Receive-side Adler-32 checker: consumes a length-prefixed frame, recomputes
// Adler-32 over the payload and compares it against the 4-byte MSB-first trailer.
module adler32_checker #(
  parameter int unsigned MOD_BASE = 65521
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        size_valid,
  input  logic [31:0] size,
  input  logic        data_valid,
  input  logic [7:0]  data,
  output logic        ready,
  output logic        done,
  output logic        checksum_ok,
  output logic [31:0] checksum_calc,
  output logic [31:0] checksum_rx
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER, DONE} state_t;

  localparam logic [16:0] MOD17 = 17'(MOD_BASE);
  localparam logic [17:0] MOD18 = 18'(MOD_BASE);

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] calc_q, calc_d;
  logic        ok_q, ok_d;

  logic        accept;
  logic [16:0] a_sum;
  logic [15:0] a_new;
  logic [17:0] b_sum;
  logic [15:0] b_new;
  logic [31:0] rx_shift;

  // A,B < MOD_BASE always, so one conditional subtraction fully reduces each sum.
  always_comb begin
    a_sum    = {1'b0, a_q} + {9'b0, data};
    a_new    = (a_sum >= MOD17) ? 16'(a_sum - MOD17) : a_sum[15:0];
    b_sum    = {2'b0, b_q} + {2'b0, a_new};
    b_new    = (b_sum >= MOD18) ? 16'(b_sum - MOD18) : b_sum[15:0];
    rx_shift = {rx_q[23:0], data};
    accept   = data_valid && ((state_q == PAYLOAD) || (state_q == TRAILER));
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= 16'd1;
      b_q        <= '0;
      count_q    <= '0;
      byte_idx_q <= '0;
      rx_q       <= '0;
      calc_q     <= 32'h0000_0001;
      ok_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      rx_q       <= rx_d;
      calc_q     <= calc_d;
      ok_q       <= ok_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    rx_d       = rx_q;
    calc_d     = calc_q;
    ok_d       = ok_q;
    unique case (state_q)
      IDLE: begin
        if (size_valid) begin
          count_d    = size;
          a_d        = 16'd1;
          b_d        = '0;
          rx_d       = '0;
          ok_d       = 1'b0;
          byte_idx_d = '0;
          state_d    = (size != '0) ? PAYLOAD : TRAILER;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          a_d     = a_new;
          b_d     = b_new;
          count_d = count_q - 32'd1;
          if (count_q == 32'd1) begin
            byte_idx_d = '0;
            state_d    = TRAILER;
          end
        end
      end
      TRAILER: begin
        if (accept) begin
          rx_d       = rx_shift;
          byte_idx_d = byte_idx_q + 2'd1;
          // Latch the verdict on the last trailer byte so it is valid alongside done.
          if (byte_idx_q == 2'd3) begin
            calc_d  = {b_q, a_q};
            ok_d    = ({b_q, a_q} == rx_shift);
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready         = (state_q == PAYLOAD) || (state_q == TRAILER);
    done          = (state_q == DONE);
    checksum_ok   = ok_q;
    checksum_calc = calc_q;
    checksum_rx   = rx_q;
  end

endmodule

// File: tb/tb_adler32_checker.sv
// Directed bench for adler32_checker: known-answer frames, bad trailer, empty
// frame, modulo wrap, stalls with ignored strobes, and mid-frame reset.
module tb_adler32_checker;

  logic        clock;
  logic        rst_n;
  logic        size_valid;
  logic [31:0] size;
  logic        data_valid;
  logic [7:0]  data;
  logic        ready;
  logic        done;
  logic        checksum_ok;
  logic [31:0] checksum_calc;
  logic [31:0] checksum_rx;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_cnt = 0;
  logic [7:0]  payload[$];
  logic [7:0]  wiki[9] = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};

  adler32_checker #(.MOD_BASE(65521)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .size_valid   (size_valid),
    .size         (size),
    .data_valid   (data_valid),
    .data         (data),
    .ready        (ready),
    .done         (done),
    .checksum_ok  (checksum_ok),
    .checksum_calc(checksum_calc),
    .checksum_rx  (checksum_rx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_wiki();
    payload.delete();
    foreach (wiki[i]) payload.push_back(wiki[i]);
  endtask

  // Sends one byte; optional stall gaps may carry an ignored size_valid pulse.
  task automatic send_byte(input logic [7:0] b, input int unsigned max_gap, input bit poke_size,
                           input bit check_mod);
    int unsigned gap;
    gap = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
    for (int unsigned g = 0; g < gap; g++) begin
      data_valid = 1'b0;
      size_valid = poke_size && (g == 0);
      size       = 32'd3;
      tick();
      size_valid = 1'b0;
    end
    check("ready", {31'b0, ready}, 32'd1);
    data_valid = 1'b1;
    data       = b;
    tick();
    data_valid = 1'b0;
    if (check_mod) begin
      check("a_below_mod", {31'b0, (dut.a_q < 16'd65521)}, 32'd1);
      check("b_below_mod", {31'b0, (dut.b_q < 16'd65521)}, 32'd1);
    end
  endtask

  task automatic run_frame(input string tag, input logic [31:0] trailer, input logic [31:0] exp_calc,
                           input bit exp_ok, input int unsigned max_gap, input bit check_mod);
    int unsigned done_before;
    logic [31:0] tr;
    tr          = trailer;
    done_before = done_cnt;
    size_valid  = 1'b1;
    size        = payload.size();
    tick();
    size_valid  = 1'b0;
    foreach (payload[i]) send_byte(payload[i], max_gap, (max_gap != 0) && (i == 3), check_mod);
    for (int i = 3; i >= 0; i--) send_byte(tr[8*i +: 8], max_gap, 1'b0, 1'b0);
    check({tag, "_done"},  {31'b0, done},  32'd1);
    check({tag, "_ready"}, {31'b0, ready}, 32'd0);
    check({tag, "_calc"},  checksum_calc,  exp_calc);
    check({tag, "_rx"},    checksum_rx,    trailer);
    check({tag, "_ok"},    {31'b0, checksum_ok}, {31'b0, exp_ok});
    tick();
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_hold_calc"}, checksum_calc, exp_calc);
    check({tag, "_done_count"}, done_cnt - done_before, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    size_valid = 1'b0;
    size       = '0;
    data_valid = 1'b0;
    data       = '0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_done",  {31'b0, done},  32'd0);
    check("rst_ok",    {31'b0, checksum_ok}, 32'd0);
    check("rst_calc",  checksum_calc, 32'h0000_0001);
    check("rst_rx",    checksum_rx,   32'h0000_0000);

    load_wiki();
    run_frame("wiki", 32'h11E6_0398, 32'h11E6_0398, 1'b1, 0, 1'b0);
    run_frame("wiki_bad", 32'h11E6_0399, 32'h11E6_0398, 1'b0, 0, 1'b0);

    payload.delete();
    run_frame("empty", 32'h0000_0001, 32'h0000_0001, 1'b1, 0, 1'b0);
    payload.push_back(8'h61);
    run_frame("one", 32'h0062_0062, 32'h0062_0062, 1'b1, 0, 1'b0);

    payload.delete();
    for (int i = 0; i < 1024; i++) payload.push_back(8'hFF);
    run_frame("wrap", 32'h79A6_FC2E, 32'h79A6_FC2E, 1'b1, 0, 1'b1);

    // data_valid in IDLE must be ignored
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1;
      data       = 8'hAA;
      tick();
      check("idle_ready", {31'b0, ready}, 32'd0);
    end
    data_valid = 1'b0;
    load_wiki();
    run_frame("stall", 32'h11E6_0398, 32'h11E6_0398, 1'b1, 5, 1'b0);

    // Abort a frame after four payload bytes with reset
    begin
      int unsigned done_before;
      done_before = done_cnt;
      size_valid  = 1'b1;
      size        = 32'd9;
      tick();
      size_valid  = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(wiki[i], 0, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("abort_ready", {31'b0, ready}, 32'd0);
      check("abort_done",  {31'b0, done},  32'd0);
      check("abort_ok",    {31'b0, checksum_ok}, 32'd0);
      check("abort_calc",  checksum_calc, 32'h0000_0001);
      check("abort_rx",    checksum_rx,   32'h0000_0000);
      tick();
      check("abort_no_done", done_cnt - done_before, 32'd0);
    end
    run_frame("post_rst", 32'h11E6_0398, 32'h11E6_0398, 1'b1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
